// File: rtl/pipelined_adder.sv
// Pipelined two's-complement adder/subtractor: STAGES carry-registered slices, valid/ready on both sides.
// Define ADDER_SAT_EN to clamp the sum to signed max/min whenever signed overflow occurs.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = WIDTH / STAGES;

    logic [WIDTH-1:0] be_s;
    logic             c0_s;
    logic             adv_s;
    logic             fire_s;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;
    logic             cmsb_s;

    assign be_s     = sub ? ~b : b;
    assign c0_s     = sub ? 1'b1 : cin;
    // A full stall freezes every stage; there is no bubble collapse.
    assign adv_s    = !out_valid_q || out_ready;
    assign fire_s   = in_valid && adv_s;
    assign in_ready = adv_s;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // op_*_s hold the not-yet-added slices, right-aligned so the current slice is [SW-1:0].
            localparam int OW = WIDTH - k * SW;
            localparam int RW = (k + 1) * SW;

            logic [OW-1:0] op_a_s;
            logic [OW-1:0] op_b_s;
            logic          cin_s;
            logic          vin_s;
            logic [SW-1:0] sl_s;
            logic          cout_s;
            logic [RW-1:0] res_s;
`ifdef ADDER_SAT_EN
            logic          msb_s;
`endif

            assign {cout_s, sl_s} = {1'b0, op_a_s[SW-1:0]} + {1'b0, op_b_s[SW-1:0]}
                                  + {{SW{1'b0}}, cin_s};

            if (k == 0) begin : g_first
                assign op_a_s = a;
                assign op_b_s = be_s;
                assign cin_s  = c0_s;
                assign vin_s  = fire_s;
                assign res_s  = sl_s;
`ifdef ADDER_SAT_EN
                assign msb_s  = a[WIDTH-1];
`endif
            end else begin : g_rest
                logic [OW-1:0]   a_q;
                logic [OW-1:0]   b_q;
                logic [k*SW-1:0] lo_q;
                logic            c_q;
                logic            v_q;
`ifdef ADDER_SAT_EN
                logic            msb_q;
`endif

                // Skew/deskew register bank between stage k-1 and stage k.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q   <= '0;
                        b_q   <= '0;
                        lo_q  <= '0;
                        c_q   <= 1'b0;
                        v_q   <= 1'b0;
`ifdef ADDER_SAT_EN
                        msb_q <= 1'b0;
`endif
                    end else if (adv_s) begin
                        a_q   <= g_stage[k-1].op_a_s[OW+SW-1:SW];
                        b_q   <= g_stage[k-1].op_b_s[OW+SW-1:SW];
                        lo_q  <= g_stage[k-1].res_s;
                        c_q   <= g_stage[k-1].cout_s;
                        v_q   <= g_stage[k-1].vin_s;
`ifdef ADDER_SAT_EN
                        msb_q <= g_stage[k-1].msb_s;
`endif
                    end
                end

                assign op_a_s = a_q;
                assign op_b_s = b_q;
                assign cin_s  = c_q;
                assign vin_s  = v_q;
                assign res_s  = {sl_s, lo_q};
`ifdef ADDER_SAT_EN
                assign msb_s  = msb_q;
`endif
            end
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB sum bit of the last slice.
    assign cmsb_s = g_stage[STAGES-1].op_a_s[SW-1] ^ g_stage[STAGES-1].op_b_s[SW-1]
                  ^ g_stage[STAGES-1].sl_s[SW-1];
    assign ovf_d  = cmsb_s ^ g_stage[STAGES-1].cout_s;

`ifdef ADDER_SAT_EN
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Clamp toward the sign of A when the signed result overflowed.
    always_comb begin
        sum_d = g_stage[STAGES-1].res_s;
        if (ovf_d) begin
            sum_d = g_stage[STAGES-1].msb_s ? SMIN : SMAX;
        end else begin
            sum_d = g_stage[STAGES-1].res_s;
        end
    end
`else
    // Wrapped result straight from the deskewed slices.
    always_comb begin
        sum_d = g_stage[STAGES-1].res_s;
    end
`endif

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (adv_s) begin
            out_valid_q <= g_stage[STAGES-1].vin_s;
            sum_q       <= sum_d;
            cout_q      <= g_stage[STAGES-1].cout_s;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4) with directed, hand-computed vectors.
module tb_pipelined_adder;

`ifdef ADDER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        int          lat;
        bit          consec;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   last_pop = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h, required %h", nm, id, act, exp);
        end
    endtask

    // Drive one operation (called just after a rising edge); push its expectation once acceptance is certain.
    task automatic issue(input int id, input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                         input logic tsub, input logic [15:0] es, input logic [15:0] es_sat,
                         input logic ec, input logic eo, input int lat, input bit consec,
                         output int waits);
        exp_t e;
        in_valid = 1'b1;
        a = ta; b = tb; cin = tcin; sub = tsub;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            chk(id, "accept_timeout", 32'd0, 32'd1);
        end else begin
            e.id = id; e.sum = SAT ? es_sat : es; e.cout = ec; e.ovf = eo;
            e.acc = cyc; e.lat = lat; e.consec = consec;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: a result transfers on the next edge whenever out_valid && out_ready mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk(0, "unexpected_out", {16'd0, sum}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    chk(e.id, "result", {14'd0, sum, cout, ovf}, {14'd0, e.sum, e.cout, e.ovf});
                    if (e.lat > 0) chk(e.id, "latency", cyc - e.acc, e.lat);
                    if (e.consec) chk(e.id, "consecutive", cyc - last_pop, 1);
                end
                last_pop = cyc;
            end
        end
    end

    logic [15:0] sa [8] = '{16'h0001, 16'h00FF, 16'h0F0F, 16'h8000, 16'h1234, 16'h0000, 16'h1234, 16'h7FFF};
    logic [15:0] sb [8] = '{16'h0001, 16'h0001, 16'h00F1, 16'h8000, 16'h4321, 16'h0001, 16'h1234, 16'hFFFF};
    logic        sc [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        ss [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] se [8] = '{16'h0002, 16'h0100, 16'h1000, 16'h0000, 16'h5556, 16'hFFFF, 16'h0000, 16'h8000};
    logic [15:0] sx [8] = '{16'h0002, 16'h0100, 16'h1000, 16'h8000, 16'h5556, 16'hFFFF, 16'h0000, 16'h7FFF};
    logic        sco[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        sov[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int w;
        int stale;
        int t;
        rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #2;
        chk(0, "rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk(0, "rst_outs", {14'd0, sum, cout, ovf}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk(0, "in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Basic add/sub vectors, unstalled: every one must take exactly 4 cycles.
        issue(1, 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 16'h2225, 1'b0, 1'b0, 4, 1'b0, w);
        issue(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 4, 1'b0, w);
        issue(3, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 16'h7FFF, 1'b0, 1'b1, 4, 1'b0, w);
        issue(4, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 4, 1'b0, w);
        issue(5, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 4, 1'b0, w);

        // Back-to-back stream of 8 with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            issue(10 + i, sa[i], sb[i], sc[i], ss[i], se[i], sx[i], sco[i], sov[i], 4, (i > 0), w);
            chk(10 + i, "in_ready_stream", w, 0);
        end
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk); #1;

        // Fill the pipe with the consumer stalled, hold 5 cycles, then drain while accepting.
        out_ready = 1'b0;
        issue(20, 16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 16'h3333, 1'b0, 1'b0, 0, 1'b0, w);
        issue(21, 16'h4444, 16'h1111, 1'b1, 1'b0, 16'h5556, 16'h5556, 1'b0, 1'b0, 0, 1'b0, w);
        issue(22, 16'h9000, 16'h1000, 1'b0, 1'b1, 16'h8000, 16'h8000, 1'b1, 1'b0, 0, 1'b0, w);
        issue(23, 16'h0FFF, 16'hF001, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 0, 1'b0, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk(30 + i, "stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk(30 + i, "stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk(30 + i, "stall_hold", {14'd0, sum, cout, ovf}, {14'd0, 16'h3333, 1'b0, 1'b0});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(24, 16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 0, 1'b0, w);
        chk(24, "accept_while_full", w, 0);
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(0, "stall_drain", q.size(), 0);
        @(posedge clk); #1;

        // Reset with 3 operations in flight.
        out_ready = 1'b0;
        issue(40, 16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 16'h0303, 1'b0, 1'b0, 0, 1'b0, w);
        issue(41, 16'h0404, 16'h0505, 1'b0, 1'b0, 16'h0909, 16'h0909, 1'b0, 1'b0, 0, 1'b0, w);
        issue(42, 16'h0606, 16'h0707, 1'b0, 1'b0, 16'h0D0D, 16'h0D0D, 1'b0, 1'b0, 0, 1'b0, w);
        @(posedge clk);
        @(negedge clk);
        chk(43, "pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk(43, "async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk(43, "async_rst_outs", {14'd0, sum, cout, ovf}, 32'd0);
        q.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk(43, "no_stale_after_rst", stale, 0);
        @(posedge clk); #1;
        issue(44, 16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 16'h0100, 1'b0, 1'b0, 4, 1'b0, w);

        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(0, "final_drain", q.size(), 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
